square_game_ctrl: RTL and testbench

Frame-synchronous controller for the on-screen square and the two-sided score. It samples the direction switches once per frame at the screen-end strobe from the VGA timing generator and moves the square with edge clamping. It detects goal crossings, runs a score/hold/game-over state machine, and drives the square bounding box consumed by the pixel colour mux and sprite address logic, plus the score values sent to the display outputs.

---
 rtl/square_game_ctrl.sv | 137 +++++++++++++
 tb/tb_square_game_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/square_game_ctrl.sv
// Frame-synchronous square/score controller: moves the square once per frame,
// detects goal crossings and sequences PLAY -> HOLD -> (PLAY | OVER).
module square_game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SQ_SIZE     = 50,
  parameter int START_X     = 270,
  parameter int START_Y     = 240,
  parameter int LEFT_GOAL   = 160,
  parameter int RIGHT_GOAL  = 430,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screen_end,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       restart,
  output logic [9:0] sq_left,
  output logic [9:0] sq_right,
  output logic [8:0] sq_top,
  output logic [8:0] sq_bottom,
  output logic [7:0] left_score,
  output logic [7:0] right_score,
  output logic       point_left,
  output logic       point_right,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [9:0]     X_START   = 10'(START_X);
  localparam logic [9:0]     X_MAX     = 10'(SCREEN_W - SQ_SIZE);
  localparam logic [9:0]     X_LGOAL   = 10'(LEFT_GOAL);
  localparam logic [9:0]     X_RGOAL   = 10'(RIGHT_GOAL);
  localparam logic [8:0]     Y_START   = 9'(START_Y);
  localparam logic [8:0]     Y_MAX     = 9'(SCREEN_H - SQ_SIZE);
  localparam logic [7:0]     WIN       = 8'(WIN_SCORE);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_FRAMES - 1);

  state_t         state_q;
  logic [9:0]     x_q;
  logic [8:0]     y_q;
  logic [HCW-1:0] hold_cnt;
  logic           screen_end_q;
  logic           tick;

  // One tick per rising edge of screen_end, however long the level stays high.
  assign tick = screen_end & ~screen_end_q;

  assign sq_left   = x_q;
  assign sq_right  = x_q + 10'(SQ_SIZE);
  assign sq_top    = y_q;
  assign sq_bottom = y_q + 9'(SQ_SIZE);
  assign state     = state_q;

  // NOTE: every register here uses non-blocking assignment so all branches
  // read the pre-update values of x_q, y_q and the scores within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      x_q          <= X_START;
      y_q          <= Y_START;
      left_score   <= '0;
      right_score  <= '0;
      hold_cnt     <= '0;
      point_left   <= 1'b0;
      point_right  <= 1'b0;
      screen_end_q <= 1'b0;
    end else begin
      screen_end_q <= screen_end;
      point_left   <= 1'b0;
      point_right  <= 1'b0;

      unique case (state_q)
        ST_PLAY: begin
          if (tick) begin
            if (x_q < X_LGOAL) begin
              right_score <= right_score + 8'd1;
              point_right <= 1'b1;
              hold_cnt    <= HOLD_LOAD;
              state_q     <= ST_HOLD;
            end else if (x_q > X_RGOAL) begin
              left_score  <= left_score + 8'd1;
              point_left  <= 1'b1;
              hold_cnt    <= HOLD_LOAD;
              state_q     <= ST_HOLD;
            end else if (btn_left) begin
              // A pressed direction at its limit still blocks lower priorities.
              if (x_q != 10'd0) x_q <= x_q - 10'd1;
            end else if (btn_right) begin
              if (x_q < X_MAX) x_q <= x_q + 10'd1;
            end else if (btn_up) begin
              if (y_q != 9'd0) y_q <= y_q - 9'd1;
            end else if (btn_down) begin
              if (y_q < Y_MAX) y_q <= y_q + 9'd1;
            end
          end
        end

        ST_HOLD: begin
          if (tick) begin
            if (hold_cnt == '0) begin
              x_q     <= X_START;
              y_q     <= Y_START;
              state_q <= (left_score == WIN || right_score == WIN) ? ST_OVER : ST_PLAY;
            end else begin
              hold_cnt <= hold_cnt - HCW'(1);
            end
          end
        end

        ST_OVER: begin
          if (restart) begin
            left_score  <= '0;
            right_score <= '0;
            x_q         <= X_START;
            y_q         <= Y_START;
            state_q     <= ST_PLAY;
          end
        end

        default: state_q <= ST_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_square_game_ctrl.sv
// Self-checking bench for square_game_ctrl: table-driven movement vectors plus
// hand-written point, hold, game-over, restart and reset sequences.
module tb_square_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       screen_end;
  logic       btn_left, btn_right, btn_up, btn_down;
  logic       restart;
  logic [9:0] sq_left, sq_right;
  logic [8:0] sq_top, sq_bottom;
  logic [7:0] left_score, right_score;
  logic       point_left, point_right;
  logic [1:0] state;

  square_game_ctrl #(.WIN_SCORE(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .screen_end  (screen_end),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .restart     (restart),
    .sq_left     (sq_left),
    .sq_right    (sq_right),
    .sq_top      (sq_top),
    .sq_bottom   (sq_bottom),
    .left_score  (left_score),
    .right_score (right_score),
    .point_left  (point_left),
    .point_right (point_right),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int left;
    int top;
    int st;
    int ls;
    int rs;
    int pl;
    int pr;
  } exp_t;

  // btn = {left, right, up, down}
  typedef struct {
    logic [3:0] btn;
    int         n;
    int         exp_left;
    int         exp_top;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input int left, input int top, input int st,
                          input int ls, input int rs, input int pl, input int pr);
    exp_t e;
    e = '{left, top, st, ls, rs, pl, pr};
    sb.push_back(e);
  endtask

  task automatic compare_next(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, nothing to compare", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, " sq_left"},     int'(sq_left),     e.left);
    check({tag, " sq_right"},    int'(sq_right),    e.left + 50);
    check({tag, " sq_top"},      int'(sq_top),      e.top);
    check({tag, " sq_bottom"},   int'(sq_bottom),   e.top + 50);
    check({tag, " state"},       int'(state),       e.st);
    check({tag, " left_score"},  int'(left_score),  e.ls);
    check({tag, " right_score"}, int'(right_score), e.rs);
    check({tag, " point_left"},  int'(point_left),  e.pl);
    check({tag, " point_right"}, int'(point_right), e.pr);
  endtask

  task automatic expect_now(input string tag, input int left, input int top, input int st,
                            input int ls, input int rs, input int pl, input int pr);
    push_exp(left, top, st, ls, rs, pl, pr);
    compare_next(tag);
  endtask

  task automatic drive_btn(input logic [3:0] b);
    {btn_left, btn_right, btn_up, btn_down} = b;
  endtask

  // Each frame: screen_end high for one cycle, low for one; ends 1 time unit after an edge.
  task automatic frames(input int n);
    repeat (n) begin
      screen_end = 1'b1;
      @(posedge clk); #1;
      screen_end = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted between edges; outputs must change without any clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    expect_now(tag, 270, 240, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b1010, 1,   270, 240};  // left+up: left wins
    vecs[1] = '{4'b0010, 250, 270, 0};    // up into top clamp
    vecs[2] = '{4'b0010, 5,   270, 0};
    vecs[3] = '{4'b0001, 500, 270, 430};  // down into bottom clamp
    vecs[4] = '{4'b0001, 1,   270, 430};
    vecs[5] = '{4'b0100, 10,  280, 430};
    vecs[6] = '{4'b0110, 1,   281, 430};  // right beats up
    vecs[7] = '{4'b0011, 30,  281, 400};  // up beats down
    vecs[8] = '{4'b0000, 3,   281, 400};
    vecs[9] = '{4'b1100, 4,   277, 400};  // left beats right

    reset = 1'b1; screen_end = 1'b0; restart = 1'b0;
    drive_btn(4'b0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_now("reset", 270, 240, 0, 0, 0, 0, 0);

    // Long screen_end level gives a single tick.
    drive_btn(4'b0100);
    screen_end = 1'b1;
    repeat (200) @(posedge clk);
    #1 screen_end = 1'b0;
    @(posedge clk); #1;
    expect_now("long_level", 271, 240, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      drive_btn(vecs[i].btn);
      frames(vecs[i].n);
      push_exp(vecs[i].exp_left, vecs[i].exp_top, 0, 0, 0, 0, 0);
      compare_next($sformatf("vec%0d", i));
    end

    drive_btn(4'b0000);
    async_reset("async_reset");

    // First point: drift left across the left goal.
    drive_btn(4'b1000);
    frames(111);
    expect_now("pre_goal", 159, 240, 0, 0, 0, 0, 0);
    screen_end = 1'b1;
    @(posedge clk); #1;
    expect_now("point_r", 159, 240, 1, 0, 1, 0, 1);
    screen_end = 1'b0;
    @(posedge clk); #1;
    expect_now("point_r_end", 159, 240, 1, 0, 1, 0, 0);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    expect_now("restart_in_hold", 159, 240, 1, 0, 1, 0, 0);
    frames(59);
    expect_now("hold_59", 159, 240, 1, 0, 1, 0, 0);
    frames(1);
    expect_now("hold_done", 270, 240, 0, 0, 1, 0, 0);

    // Second point: drift right across the right goal.
    drive_btn(4'b0100);
    frames(161);
    expect_now("pre_rgoal", 431, 240, 0, 0, 1, 0, 0);
    screen_end = 1'b1;
    @(posedge clk); #1;
    expect_now("point_l", 431, 240, 1, 1, 1, 1, 0);
    screen_end = 1'b0;
    @(posedge clk); #1;
    frames(59);
    frames(1);
    expect_now("hold2_done", 270, 240, 0, 1, 1, 0, 0);

    // Third point reaches WIN_SCORE=2 on the right.
    drive_btn(4'b1000);
    frames(112);
    expect_now("point3", 159, 240, 1, 1, 2, 0, 0);
    frames(60);
    expect_now("game_over", 270, 240, 2, 1, 2, 0, 0);
    frames(5);
    expect_now("over_frozen", 270, 240, 2, 1, 2, 0, 0);

    // Restart and tick together: restart wins, no move.
    drive_btn(4'b0100);
    restart = 1'b1;
    screen_end = 1'b1;
    @(posedge clk); #1;
    expect_now("restart", 270, 240, 0, 0, 0, 0, 0);
    restart = 1'b0;
    screen_end = 1'b0;
    @(posedge clk); #1;
    frames(1);
    expect_now("after_restart", 271, 240, 0, 0, 0, 0, 0);
    restart = 1'b1;
    frames(1);
    restart = 1'b0;
    expect_now("restart_in_play", 272, 240, 0, 0, 0, 0, 0);

    // Reset in the middle of HOLD (hold_cnt = 30).
    drive_btn(4'b1000);
    frames(113);
    frames(1);
    expect_now("point4", 159, 240, 1, 0, 1, 0, 0);
    frames(29);
    expect_now("hold_mid", 159, 240, 1, 0, 1, 0, 0);
    async_reset("reset_mid_hold");
    drive_btn(4'b0100);
    frames(1);
    expect_now("move_after_reset", 271, 240, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
